// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Optional build macro: RF_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  // x0 is hardwired to zero and can never be pending
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register-file read, write and scoreboard signals.
// master = issue/writeback side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(DEPTH)
);
  logic [NUM_WR-1:0]           RegWrite;
  logic [NUM_WR-1:0][AW-1:0]   writereg;
  logic [NUM_WR-1:0][XLEN-1:0] writeData;
  logic [NUM_RD-1:0][AW-1:0]   readReg;
  logic [NUM_RD-1:0][XLEN-1:0] readData;
  logic                        alloc_en;
  logic [AW-1:0]               alloc_reg;
  logic [DEPTH-1:0]            pending;
  logic [NUM_RD-1:0]           rd_busy;

  modport master (
    output RegWrite, writereg, writeData, readReg, alloc_en, alloc_reg,
    input  readData, pending, rd_busy
  );

  modport slave (
    input  RegWrite, writereg, writeData, readReg, alloc_en, alloc_reg,
    output readData, pending, rd_busy
  );
endinterface

// File: rtl/regfile_mp_rf_wr_arbiter.sv
// Per-register write select across all write ports; the highest-indexed
// port targeting a register wins. Register 0 never sees a write enable.
module rf_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 32,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i,
  output logic [DEPTH-1:0]            reg_we_o,
  output logic [DEPTH-1:0][XLEN-1:0]  reg_wdata_o
);

  // Later ports overwrite earlier matches, giving highest-index priority
  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (r != int'(ZERO_REG)) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w] == AW'(r))) begin
            reg_we_o[r]    = 1'b1;
            reg_wdata_o[r] = wr_data_i[w];
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0, asynchronous
// reset and a per-register pending bit for issue stalling.
// Optional build macro: RF_BYPASS_EN forwards same-cycle writes to reads
// and masks rd_busy for forwarded operands.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave rf
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]            rf_q [DEPTH];
  logic [DEPTH-1:0]           pending_q;
  logic [DEPTH-1:0]           pending_d;
  logic [DEPTH-1:0]           reg_we;
  logic [DEPTH-1:0][XLEN-1:0] reg_wdata;

  rf_wr_arbiter #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_wr_arb (
    .wr_en_i     (rf.RegWrite),
    .wr_addr_i   (rf.writereg),
    .wr_data_i   (rf.writeData),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata)
  );

  // Storage update; x0 is only ever loaded by reset so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (reg_we[i]) rf_q[i] <= reg_wdata[i];
      end
    end
  end

  // Writeback clears, then a same-cycle allocation sets (newer producer)
  always_comb begin
    pending_d = pending_q & ~reg_we;
    if (rf.alloc_en && (rf.alloc_reg != ZERO_ADDR)) pending_d[rf.alloc_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rf.pending = pending_q;

  // Combinational read ports
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef RF_BYPASS_EN
    assign rf.readData[gi] = reg_we[rf.readReg[gi]] ? reg_wdata[rf.readReg[gi]]
                                                    : rf_q[rf.readReg[gi]];
    assign rf.rd_busy[gi]  = pending_q[rf.readReg[gi]] & ~reg_we[rf.readReg[gi]];
`else
    assign rf.readData[gi] = rf_q[rf.readReg[gi]];
    assign rf.rd_busy[gi]  = pending_q[rf.readReg[gi]];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DEPTH=32, NUM_RD=3, NUM_WR=2).
// Stimulus pushes expectations; the monitor pops and compares on each sample.
module tb_regfile_mp;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 3;
  localparam int NUM_WR = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) rf_if ();

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  typedef struct {
    int          kind;   // 0 readData, 1 pending vector, 2 rd_busy
    int          idx;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   passed = 0;

  // Monitor: compares every queued expectation when a sample is presented
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t        e;
        logic [63:0] act;
        e = sb.pop_front();
        case (e.kind)
          0:       act = rf_if.readData[e.idx];
          1:       act = {32'b0, rf_if.pending};
          default: act = {63'b0, rf_if.rd_busy[e.idx]};
        endcase
        checks++;
        if (act === e.exp) begin
          passed++;
          $display("ok   %s act=%h exp=%h", e.name, act, e.exp);
        end else begin
          $display("FAIL %s act=%h exp=%h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic clr_inputs();
    rf_if.RegWrite  = '0;
    rf_if.writereg  = '0;
    rf_if.writeData = '0;
    rf_if.readReg   = '0;
    rf_if.alloc_en  = 1'b0;
    rf_if.alloc_reg = '0;
  endtask

  task automatic exp_rd(int k, logic [63:0] v, string n);
    sb.push_back('{0, k, v, n});
  endtask

  task automatic exp_pend(logic [31:0] v, string n);
    sb.push_back('{1, 0, {32'b0, v}, n});
  endtask

  task automatic exp_busy(int k, bit v, string n);
    sb.push_back('{2, k, {63'b0, v}, n});
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int p, int a, logic [63:0] d);
    rf_if.RegWrite[p]  = 1'b1;
    rf_if.writereg[p]  = 5'(a);
    rf_if.writeData[p] = d;
  endtask

  // Reference state for the random regression
  logic [63:0] m_rf [DEPTH];
  logic [31:0] m_pend;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_inputs();
    // ---- 1. reset: everything reads zero
    #3;
    sample();
    exp_pend(32'h0, "pend_in_reset");
    exp_rd(0, 64'h0, "rd_in_reset");
    sample();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < NUM_RD; k++) rf_if.readReg[k] = 5'(i);
      for (int k = 0; k < NUM_RD; k++) exp_rd(k, 64'h0, $sformatf("reset_x%0d_p%0d", i, k));
      sample();
    end
    exp_pend(32'h0, "reset_pend");
    sample();

    // mid-run async reset after x5 = 0xDEAD
    tick();
    wr(0, 5, 64'hDEAD);
    tick();
    clr_inputs();
    rf_if.readReg[0] = 5'd5;
    exp_rd(0, 64'hDEAD, "x5_before_rst");
    sample();
    rst = 1'b1;
    exp_rd(0, 64'h0, "x5_async_rst");
    exp_pend(32'h0, "pend_async_rst");
    sample();
    tick();
    // write presented as reset deasserts is taken on the next edge
    rst = 1'b0;
    wr(0, 5, 64'h77);
    tick();
    clr_inputs();
    rf_if.readReg[0] = 5'd5;
    exp_rd(0, 64'h77, "x5_write_at_rst_release");
    sample();

    // ---- 2. same-cycle read of a write
    wr(0, 7, 64'h1234_5678_9ABC_DEF0);
    rf_if.readReg[0] = 5'd7;
    exp_rd(0, BYP ? 64'h1234_5678_9ABC_DEF0 : 64'h0, "x7_same_cycle");
    sample();
    tick();
    clr_inputs();
    rf_if.readReg[0] = 5'd7;
    exp_rd(0, 64'h1234_5678_9ABC_DEF0, "x7_next_cycle");
    sample();

    // ---- 3. x0 ignores writes and allocation
    wr(0, 0, 64'hFFFF);
    rf_if.alloc_en  = 1'b1;
    rf_if.alloc_reg = 5'd0;
    rf_if.readReg[1] = 5'd0;
    exp_rd(1, 64'h0, "x0_same_cycle");
    sample();
    tick();
    clr_inputs();
    exp_rd(0, 64'h0, "x0_after_write");
    exp_pend(32'h0, "pend0_after_alloc");
    exp_busy(0, 1'b0, "busy_x0");
    sample();

    // ---- 4. two ports to x3: port1 wins
    wr(0, 3, 64'hAA);
    wr(1, 3, 64'hBB);
    rf_if.readReg[1] = 5'd3;
    exp_rd(1, BYP ? 64'hBB : 64'h0, "x3_conflict_same_cycle");
    sample();
    tick();
    clr_inputs();
    rf_if.readReg[1] = 5'd3;
    exp_rd(1, 64'hBB, "x3_conflict_next");
    sample();

    // ---- 5. pending scoreboard on x9
    rf_if.alloc_en  = 1'b1;
    rf_if.alloc_reg = 5'd9;
    tick();
    clr_inputs();
    rf_if.readReg[2] = 5'd9;
    exp_pend(32'h0000_0200, "pend9_set");
    exp_busy(2, 1'b1, "busy_x9");
    exp_busy(0, 1'b0, "busy_x0_while_x9");
    sample();
    wr(0, 9, 64'h5);
    exp_busy(2, BYP ? 1'b0 : 1'b1, "busy_x9_during_write");
    exp_rd(2, BYP ? 64'h5 : 64'h0, "x9_during_write");
    sample();
    tick();
    clr_inputs();
    rf_if.readReg[2] = 5'd9;
    exp_pend(32'h0, "pend9_cleared");
    exp_rd(2, 64'h5, "x9_after_write");
    exp_busy(2, 1'b0, "busy_x9_cleared");
    sample();
    rf_if.alloc_en  = 1'b1;
    rf_if.alloc_reg = 5'd9;
    wr(1, 9, 64'h66);
    tick();
    clr_inputs();
    rf_if.readReg[2] = 5'd9;
    exp_pend(32'h0000_0200, "pend9_alloc_and_write");
    exp_rd(2, 64'h66, "x9_alloc_and_write");
    exp_busy(2, 1'b1, "busy_x9_alloc_and_write");
    sample();

    // ---- 6. random regression against a reference model
    rst = 1'b1;
    sample();
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
    m_pend = '0;
    for (int c = 0; c < 300; c++) begin
      logic [4:0]  wa [NUM_WR];
      logic [63:0] wd [NUM_WR];
      logic        we [NUM_WR];
      logic        ae;
      logic [4:0]  ar;
      clr_inputs();
      for (int w = 0; w < NUM_WR; w++) begin
        we[w] = ($urandom_range(0, 1) == 1);
        wa[w] = 5'($urandom_range(0, 7));
        wd[w] = {$urandom, $urandom};
        rf_if.RegWrite[w]  = we[w];
        rf_if.writereg[w]  = wa[w];
        rf_if.writeData[w] = wd[w];
      end
      ae = ($urandom_range(0, 2) == 0);
      ar = 5'($urandom_range(0, 7));
      rf_if.alloc_en  = ae;
      rf_if.alloc_reg = ar;
      for (int k = 0; k < NUM_RD; k++) begin
        logic [4:0]  a;
        logic [63:0] v;
        logic        hit;
        a = 5'($urandom_range(0, 7));
        rf_if.readReg[k] = a;
        v   = m_rf[a];
        hit = 1'b0;
        if (BYP && a != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (we[w] && wa[w] == a) begin
              v   = wd[w];
              hit = 1'b1;
            end
          end
        end
        exp_rd(k, v, $sformatf("rand%0d_rd%0d_x%0d", c, k, a));
        exp_busy(k, m_pend[a] & ~hit, $sformatf("rand%0d_busy%0d_x%0d", c, k, a));
      end
      exp_pend(m_pend, $sformatf("rand%0d_pend", c));
      sample();
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && wa[w] != 0) begin
          m_rf[wa[w]]   = wd[w];
          m_pend[wa[w]] = 1'b0;
        end
      end
      if (ae && ar != 0) m_pend[ar] = 1'b1;
      tick();
    end

    clr_inputs();
    sample();
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain act=%0d exp=0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
